pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and next-PC stage of the RISC-V core, directly downstream of the branch unit. Consumes the branch unit's `taken` decision together with the jump controls and EX-stage operands, and computes the redirect target. Owns the fetch PC register, flushes wrong-path instructions, defers redirects while instruction memory is not ready, and traps on misaligned targets.

## Interface
- `XLEN`, 32: address width.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on misaligned-target trap.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_ready`  in  1  instruction memory accepts `pc` this cycle; PC may advance only when 1.
- `taken`  in  1  branch taken, already gated by Branch.
- `Jump`  in  1  JAL in EX.
- `JumpReg`  in  1  JALR in EX.
- `pc_ex`  in  XLEN  PC of the instruction in EX.
- `imm_ex`  in  XLEN  sign-extended immediate of the instruction in EX.
- `rs1_ex`  in  XLEN  forwarded rs1 value of the instruction in EX.
- `pc`  out  XLEN  current fetch address (registered).
- `pc_plus4`  out  XLEN  `pc + 4`, combinational.
- `flush`  out  1  kill IF/ID contents at next edge.
- `trap`  out  1  one-cycle misaligned-target pulse (registered).
- `bad_addr`  out  XLEN  offending target of last trap (registered).

## Operation
- `redir_req = taken | Jump | JumpReg`.
- Target: `JumpReg` → `(rs1_ex + imm_ex) & ~1`; otherwise `pc_ex + imm_ex`. All sums modulo 2^XLEN, no overflow detection.
- Misaligned when `target[1:0] != 0` (no C extension).
- States:
  - RUN: no pending redirect.
  - PEND: redirect captured, waiting for `fetch_ready`.
  - Holding register `pend_tgt` and flag `pend_mis`.
- RUN transitions:
  - `redir_req & fetch_ready`: aligned → `pc <= target`; misaligned → `pc <= TRAP_VEC`, `bad_addr <= target`, `trap <= 1`. Stay RUN.
  - `redir_req & !fetch_ready`: `pend_tgt <= target`, `pend_mis <= misaligned`, go PEND; `pc` holds.
  - `!redir_req & fetch_ready`: `pc <= pc + 4`.
  - Neither: hold.
- PEND transitions:
  - `redir_req` ignored; those instructions are wrong-path.
  - `fetch_ready=1`: apply `pend_tgt`, or trap if `pend_mis` (same actions as RUN), then go RUN.
  - `fetch_ready=0`: hold.
- `flush` (combinational) = `rst_n & ((state==RUN & redir_req) | state==PEND)`.
- `trap` is 1 only in the cycle following a trap-taking edge; otherwise 0.
- `bad_addr` changes only on trap.
- Reset (async, any state): `pc=RESET_PC`, state RUN, `pend_tgt=0`, `pend_mis=0`, `trap=0`, `bad_addr=0`; `flush` forced 0 while `rst_n=0`. A pending redirect is discarded.

## Timing
- Redirect latency:
  - EX resolves in cycle N with `fetch_ready=1`: `flush=1` in N; `pc=target` from N+1.
  - Penalty: 2 wrong-path instructions (IF, ID).
- Deferred redirect: `pc=target` the cycle after the first `fetch_ready=1` edge; `flush` high throughout PEND.
- Sequential fetch: one `pc+4` step per edge with `fetch_ready=1`.
- Wrap-around: `pc=32'hFFFF_FFFC` advances to `32'h0000_0000`.
- Simultaneous `taken` and `Jump`: same target path; `JumpReg` selects rs1 base regardless of others.
- Reset deassertion: first advance on the first edge with `rst_n=1` and `fetch_ready=1`.

## Test plan
- Reset, then `fetch_ready=1` for 3 cycles, no redirects → `pc` 0x0, 0x4, 0x8, 0xC; `flush=0`, `trap=0`.
- `pc_ex=0x40`, `imm_ex=0x20`, `taken=1`, `fetch_ready=1` → `flush=1` that cycle; `pc=0x60` next cycle.
- `JumpReg=1`, `rs1_ex=0x1001`, `imm_ex=0x4` → `pc=0x1004` (bit0 cleared); no trap.
- `Jump=1`, `pc_ex=0x10`, `imm_ex=0x6`, `fetch_ready=1` → `pc=0x100`, `trap=1` for one cycle, `bad_addr=0x16`.
- `taken=1` (target 0x200) with `fetch_ready=0` for 3 cycles; second `Jump` (target 0x300) during PEND → `flush=1` all 3 cycles, `pc` held; on `fetch_ready=1`, `pc=0x200` next cycle; the Jump is ignored.
- Hold state in PEND, assert `rst_n=0` mid-cycle → immediately `pc=RESET_PC`, `flush=0`; after release, fetch resumes from 0x0 and the pending target is never applied.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter / next-PC stage: owns the fetch PC, resolves redirects from
// the branch unit and jump controls, defers them while instruction memory is
// busy, and traps to TRAP_VEC on word-misaligned targets.
module pc_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  input  logic            taken,
  input  logic            Jump,
  input  logic            JumpReg,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] rs1_ex,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            trap,
  output logic [XLEN-1:0] bad_addr
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic            redir_req;
  logic [XLEN-1:0] jr_sum;
  logic [XLEN-1:0] target;
  logic            target_mis;

  // Redirect target: JALR uses rs1 as base with bit 0 cleared; branch/JAL use pc_ex.
  always_comb begin
    redir_req  = taken | Jump | JumpReg;
    jr_sum     = rs1_ex + imm_ex;
    target     = JumpReg ? (jr_sum & ~XLEN'(1)) : (pc_ex + imm_ex);
    target_mis = (target[1:0] != 2'b00);
  end

  logic            apply_en;
  logic [XLEN-1:0] apply_tgt;
  logic            apply_mis;

  // Next-state and next-PC selection; a redirect is "applied" either directly
  // from EX or later from the holding register, with identical trap handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    trap_d     = 1'b0;
    bad_addr_d = bad_addr_q;
    apply_en   = 1'b0;
    apply_tgt  = target;
    apply_mis  = target_mis;

    case (state_q)
      RUN: begin
        if (redir_req && fetch_ready) begin
          apply_en = 1'b1;
        end else if (redir_req) begin
          pend_tgt_d = target;
          pend_mis_d = target_mis;
          state_d    = PEND;
        end else if (fetch_ready) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      PEND: begin
        // New redirect requests here come from wrong-path instructions.
        if (fetch_ready) begin
          apply_en  = 1'b1;
          apply_tgt = pend_tgt_q;
          apply_mis = pend_mis_q;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (apply_en) begin
      if (apply_mis) begin
        pc_d       = TRAP_VEC;
        bad_addr_d = apply_tgt;
        trap_d     = 1'b1;
      end else begin
        pc_d = apply_tgt;
      end
    end
  end

  // State and PC registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      trap_q     <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
      trap_q     <= trap_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign trap     = trap_q;
  assign bad_addr = bad_addr_q;
  assign flush    = rst_n & (((state_q == RUN) & redir_req) | (state_q == PEND));

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the hand-computed expected
// outputs for each cycle; a monitor pops and compares on the falling edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready;
  logic        taken;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] pc_ex;
  logic [31:0] imm_ex;
  logic [31:0] rs1_ex;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        trap;
  logic [31:0] bad_addr;

  pc_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_ready(fetch_ready),
    .taken      (taken),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .pc_ex      (pc_ex),
    .imm_ex     (imm_ex),
    .rs1_ex     (rs1_ex),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .flush      (flush),
    .trap       (trap),
    .bad_addr   (bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_vec = 0;

  task automatic check32(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: compare every cycle for which the driver queued an expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check32("pc",       e.id, pc,              e.pc);
        check32("pc_plus4", e.id, pc_plus4,        e.pc + 32'd4);
        check32("flush",    e.id, {31'b0, flush},  {31'b0, e.flush});
        check32("trap",     e.id, {31'b0, trap},   {31'b0, e.trap});
        check32("bad_addr", e.id, bad_addr,        e.bad);
        $display("vec%0d: pc=%h flush=%0b trap=%0b bad_addr=%h", e.id, pc, flush, trap, bad_addr);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that same cycle.
  task automatic vec(input logic rn, input logic fr, input logic tk, input logic j, input logic jr,
                     input logic [31:0] pex, input logic [31:0] imm, input logic [31:0] rs1,
                     input logic [31:0] e_pc, input logic e_fl, input logic e_tr, input logic [31:0] e_bad);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rn;
    fetch_ready = fr;
    taken       = tk;
    Jump        = j;
    JumpReg     = jr;
    pc_ex       = pex;
    imm_ex      = imm;
    rs1_ex      = rs1;
    n_vec++;
    e.id    = n_vec;
    e.pc    = e_pc;
    e.flush = e_fl;
    e.trap  = e_tr;
    e.bad   = e_bad;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; taken = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    pc_ex = '0; imm_ex = '0; rs1_ex = '0;

    //   rn fr tk j  jr  pc_ex         imm_ex        rs1_ex        pc            fl tr bad
    // Reset: flush suppressed even with a request present.
    vec(0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    // Sequential fetch from RESET_PC.
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 0, 0, 32'h0);
    // Taken branch 0x40+0x20 -> 0x60.
    vec(1, 1, 1, 0, 0, 32'h40,       32'h20,       32'h0,        32'h0000_000C, 1, 0, 32'h0);
    // JALR 0x1001+4 = 0x1005, bit0 cleared -> 0x1004.
    vec(1, 1, 0, 0, 1, 32'h0,        32'h4,        32'h1001,     32'h0000_0060, 1, 0, 32'h0);
    // JAL 0x10+6 = 0x16 misaligned -> trap.
    vec(1, 1, 0, 1, 0, 32'h10,       32'h6,        32'h0,        32'h0000_1004, 1, 0, 32'h0);
    vec(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 1, 32'h16);
    vec(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 0, 32'h16);
    // Deferred branch to 0x200; Jump to 0x300 during PEND is ignored.
    vec(1, 0, 1, 0, 0, 32'h100,      32'h100,      32'h0,        32'h0000_0100, 1, 0, 32'h16);
    vec(1, 0, 0, 1, 0, 32'h200,      32'h100,      32'h0,        32'h0000_0100, 1, 0, 32'h16);
    vec(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 1, 0, 32'h16);
    vec(1, 1, 0, 1, 0, 32'h200,      32'h100,      32'h0,        32'h0000_0100, 1, 0, 32'h16);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0200, 0, 0, 32'h16);
    // Jump to 0xFFFFFFFC, then wrap to 0.
    vec(1, 1, 0, 1, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0000_0204, 1, 0, 32'h16);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, 0, 0, 32'h16);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h16);
    // All three asserted: JumpReg wins, 0x500+0x11=0x511 -> 0x510.
    vec(1, 1, 1, 1, 1, 32'h80,       32'h11,       32'h500,      32'h0000_0004, 1, 0, 32'h16);
    // taken+Jump: pc_ex base, 0x80+0x10 -> 0x90.
    vec(1, 1, 1, 1, 0, 32'h80,       32'h10,       32'h500,      32'h0000_0510, 1, 0, 32'h16);
    // Deferred misaligned target 0x2 -> trap on release.
    vec(1, 0, 1, 0, 0, 32'h0,        32'h2,        32'h0,        32'h0000_0090, 1, 0, 32'h16);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0090, 1, 0, 32'h16);
    vec(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 1, 32'h2);
    // Enter PEND with target 0x400, then reset mid-cycle.
    vec(1, 0, 1, 0, 0, 32'h0,        32'h400,      32'h0,        32'h0000_0100, 1, 0, 32'h2);
    vec(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 1, 0, 32'h2);
    vec(0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    // Fetch resumes from 0; the discarded 0x400 never appears.
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0);
    vec(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 0, 0, 32'h0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
